// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit with ID/EX stall handshake
`timescale 1ns/1ps
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic            in_valid,
    input  logic            in_md,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_reg1,
    input  logic [XLEN-1:0] in_reg2,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            stall_req,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_data
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              sign_q, sign_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;

    logic            rs1_signed, rs2_signed;
    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic            sign_in;
    logic            accept;
    logic            last;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next, quo_next;

    always_comb begin
        rs1_signed = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010)
                  || (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
        rs2_signed = (in_funct3 == 3'b000) || (in_funct3 == 3'b001)
                  || (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
        s1       = rs1_signed & in_reg1[XLEN-1];
        s2       = rs2_signed & in_reg2[XLEN-1];
        mag1     = s1 ? -in_reg1 : in_reg1;
        mag2     = s2 ? -in_reg2 : in_reg2;
        div_zero = (in_reg2 == '0);
        // Signed DIV/REM of the most negative value by -1 overflows the quotient.
        div_ovf  = in_funct3[2] & ~in_funct3[0]
                 & (in_reg1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_reg2 == '1);
        case (in_funct3)
            3'b000, 3'b001: sign_in = s1 ^ s2;
            3'b010:         sign_in = s1;
            3'b100:         sign_in = (s1 ^ s2) & ~div_zero;
            3'b110:         sign_in = s1;
            default:        sign_in = 1'b0;
        endcase
    end

    assign accept    = (state_q == IDLE) & in_valid & in_md & ~flush;
    assign stall_req = accept | (state_q == CALC) | (state_q == DONE);
    assign last      = (cnt_q == CW'(ITER - 1));

    // Multiplier sits in the low half of prod_q and shifts out as the sum shifts in.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opa_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opa_q};
        div_ge    = ~div_diff[XLEN];
        rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], div_ge};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        sign_d      = sign_q;
        opa_d       = opa_q;
        prod_d      = prod_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        if (rdy) begin
            out_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_d = in_funct3;
                        rd_d     = in_rd;
                        sign_d   = sign_in;
                        cnt_d    = '0;
                        rem_d    = '0;
                        if (in_funct3[2]) begin
                            opa_d   = mag2;
                            quo_d   = mag1;
                            state_d = CALC;
                            if (div_zero) begin
                                quo_d   = '1;
                                rem_d   = in_reg1;
                                state_d = DONE;
                            end else if (div_ovf) begin
                                quo_d   = in_reg1;
                                state_d = DONE;
                            end
                        end else begin
                            opa_d   = mag1;
                            prod_d  = {{XLEN{1'b0}}, mag2};
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (funct3_q[2]) begin
                            quo_d = quo_next;
                            rem_d = rem_next;
                            if (last && sign_q) begin
                                if (funct3_q[1]) rem_d = -rem_next;
                                else             quo_d = -quo_next;
                            end
                        end else begin
                            prod_d = (last && sign_q) ? -mul_next : mul_next;
                        end
                        if (last) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (!flush) begin
                        out_valid_d = 1'b1;
                        out_rd_d    = rd_q;
                        if (funct3_q[2])
                            out_data_d = funct3_q[1] ? rem_q : quo_q;
                        else if (funct3_q == 3'b000)
                            out_data_d = prod_q[XLEN-1:0];
                        else
                            out_data_d = prod_q[2*XLEN-1:XLEN];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            sign_q      <= 1'b0;
            opa_q       <= '0;
            prod_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            sign_q      <= sign_d;
            opa_q       <= opa_d;
            prod_q      <= prod_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;

endmodule
